// File: rtl/imem_pipe.sv
// Pipelined instruction store for the MIPS fetch path: loader write port, 1- or 2-cycle
// read pipeline with valid/ready back-pressure, error flagging and fetch/error counters.
module imem_pipe #(
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 32,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_instr,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic [31:0]              fetch_cnt,
  output logic [15:0]              err_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  generate
    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
      $error("imem_pipe: LATENCY must be 1 or 2");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("imem_pipe: DEPTH must be a power of two and at least 4");
    end
  endgenerate

  // Misaligned, or word index beyond the end of the array.
  function automatic logic addr_err_f(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] word_s;
    word_s = {2'b00, a[ADDR_W-1:2]};
    return (a[1:0] != 2'b00) || (word_s >= ADDR_W'(DEPTH));
  endfunction

  // The array powers up as all-NOP and is deliberately left out of reset.
  logic [31:0]        mem_r [DEPTH] = '{default: NOP_WORD};

  logic [LATENCY-1:0] vld_r;
  logic [LATENCY-1:0] err_r;
  logic [31:0]        instr_r [LATENCY];
  logic [ADDR_W-1:0]  addr_r  [LATENCY];
  logic [31:0]        fetch_cnt_r;
  logic [15:0]        err_cnt_r;

  logic               adv_s;
  logic               acc_s;
  logic               req_err_s;
  logic [IDX_W-1:0]   req_idx_s;
  logic [31:0]        req_word_s;

  assign adv_s     = !vld_r[LATENCY-1] | rsp_ready;
  assign req_ready = adv_s & !ld_en;
  assign acc_s     = req_valid & req_ready;
  assign req_err_s = addr_err_f(req_addr);
  assign req_idx_s = req_addr[2 +: IDX_W];

  // Word presented to stage 0: array contents, or NOP for an error fetch.
  always_comb begin
    req_word_s = NOP_WORD;
    if (req_err_s) begin
      req_word_s = NOP_WORD;
    end else begin
      req_word_s = mem_r[req_idx_s];
    end
  end

  // Loader write port; never gated by reset or back-pressure.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

  // Response pipeline: every stage shifts together on adv, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= '0;
      err_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        instr_r[i] <= NOP_WORD;
        addr_r[i]  <= '0;
      end
    end else if (adv_s) begin
      vld_r[0]   <= acc_s;
      err_r[0]   <= req_err_s;
      instr_r[0] <= req_word_s;
      addr_r[0]  <= req_addr;
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i]   <= vld_r[i-1];
        err_r[i]   <= err_r[i-1];
        instr_r[i] <= instr_r[i-1];
        addr_r[i]  <= addr_r[i-1];
      end
    end
  end

  // Fetch counter wraps; error counter saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_r <= 32'd0;
      err_cnt_r   <= 16'd0;
    end else if (acc_s) begin
      fetch_cnt_r <= fetch_cnt_r + 32'd1;
      if (req_err_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign rsp_valid = vld_r[LATENCY-1];
  assign rsp_err   = err_r[LATENCY-1];
  assign rsp_instr = instr_r[LATENCY-1];
  assign rsp_addr  = addr_r[LATENCY-1];
  assign fetch_cnt = fetch_cnt_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_imem_pipe.sv
// Bench for imem_pipe: one instance per LATENCY (1 and 2), a transaction-level model
// checked every cycle, and directed sequences with hand-computed expectations.
module tb_imem_pipe;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rsp_ready = 1'b1;
  logic        ld_en = 1'b0;
  logic [1:0]  reqv = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [6:0]  ld_addr = 7'd0;
  logic [31:0] ld_data = 32'h0;

  logic [1:0]  rdy, rv, rerr;
  logic [31:0] rins [2];
  logic [31:0] raddr [2];
  logic [31:0] fcnt [2];
  logic [15:0] ecnt [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_pipe #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(g + 1), .NOP_WORD(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqv[g]), .req_ready(rdy[g]), .req_addr(req_addr),
      .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_instr(rins[g]),
      .rsp_addr(raddr[g]), .rsp_err(rerr[g]),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .fetch_cnt(fcnt[g]), .err_cnt(ecnt[g]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: expected responses as a queue per instance ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    int          age;   // adv edges seen since acceptance
  } ent_t;

  ent_t        mq [2][$];
  logic [31:0] mmem [DEPTH];
  logic [31:0] mfetch [2];
  logic [15:0] merr [2];
  bit          live = 1'b0;

  function automatic bit exp_valid(input int d);
    return (mq[d].size() > 0) && (mq[d][0].age >= d + 1);
  endfunction

  initial begin
    bit   ev, adv, acc, e;
    ent_t n;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        ev  = exp_valid(d);
        adv = !ev || rsp_ready;
        acc = reqv[d] && adv && !ld_en;
        if (!rst_n) begin
          mq[d].delete();
          mfetch[d] = 32'd0;
          merr[d]   = 16'd0;
        end else if (adv) begin
          if (ev) void'(mq[d].pop_front());
          for (int i = 0; i < mq[d].size(); i++) mq[d][i].age++;
          if (acc) begin
            e = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
            if (e) n.instr = 32'h0;
            else   n.instr = mmem[req_addr / 4];
            n.addr = req_addr;
            n.err  = e;
            n.age  = 1;
            mq[d].push_back(n);
            mfetch[d] = mfetch[d] + 32'd1;
            if (e && merr[d] != 16'hFFFF) merr[d] = merr[d] + 16'd1;
          end
        end
      end
      if (ld_en) mmem[ld_addr] = ld_data;
      live = 1'b1;
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (live) begin
        for (int d = 0; d < 2; d++) begin
          ev = exp_valid(d);
          chk($sformatf("model rsp_valid[%0d]", d), rv[d], ev);
          chk($sformatf("model req_ready[%0d]", d), rdy[d], (!ev || rsp_ready) && !ld_en);
          chk($sformatf("model fetch_cnt[%0d]", d), fcnt[d], mfetch[d]);
          chk($sformatf("model err_cnt[%0d]", d), ecnt[d], merr[d]);
          if (ev) begin
            chk($sformatf("model rsp_instr[%0d]", d), rins[d], mq[d][0].instr);
            chk($sformatf("model rsp_addr[%0d]", d), raddr[d], mq[d][0].addr);
            chk($sformatf("model rsp_err[%0d]", d), rerr[d], mq[d][0].err);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input int d, input logic [31:0] ins, input logic [31:0] a,
                            input logic e);
    chk("lit rsp_valid", rv[d], 1'b1);
    chk("lit rsp_instr", rins[d], ins);
    chk("lit rsp_addr", raddr[d], a);
    chk("lit rsp_err", rerr[d], e);
  endtask

  task automatic fetch_one(input int d, input logic [31:0] a, input logic [31:0] ins,
                           input logic e);
    reqv[d] = 1'b1;
    req_addr = a;
    #1;
    chk("lit fetch req_ready", rdy[d], 1'b1);
    tick();
    reqv[d] = 1'b0;
    for (int i = 1; i < d + 1; i++) begin
      chk("lit early rsp_valid", rv[d], 1'b0);
      tick();
    end
    expect_rsp(d, ins, a, e);
    tick();
  endtask

  task automatic present(input int d, input logic [31:0] a);
    bit done;
    done = 1'b0;
    reqv[d] = 1'b1;
    req_addr = a;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (rdy[d]) done = 1'b1;
      tick();
    end
    chk("present accepted", done, 1'b1);
  endtask

  task automatic stall(input int d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (rv[d]) seen = 1'b1;
    end
    chk("stall response seen", seen, 1'b1);
    rsp_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("stall req_ready", rdy[d], 1'b0);
      chk("stall rsp_valid", rv[d], 1'b1);
      chk("stall rsp_instr", rins[d], 32'h2003000C);
      chk("stall rsp_addr", raddr[d], 32'h4);
      chk("stall fetch_cnt", fcnt[d], 32'(6 + d + 1));
      chk("stall err_cnt", ecnt[d], 16'd2);
      tick();
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      // Reset, with a request presented that must be discarded.
      rst_n = 1'b0; rsp_ready = 1'b1; ld_en = 1'b0;
      reqv[d] = 1'b1; req_addr = 32'h0;
      tick();
      chk("reset rsp_valid", rv[d], 1'b0);
      chk("reset rsp_instr", rins[d], 32'h0);
      chk("reset rsp_addr", raddr[d], 32'h0);
      chk("reset rsp_err", rerr[d], 1'b0);
      chk("reset fetch_cnt", fcnt[d], 32'd0);
      chk("reset err_cnt", ecnt[d], 16'd0);
      chk("reset req_ready", rdy[d], 1'b1);
      reqv[d] = 1'b0;
      ld_en = 1'b1; ld_addr = 7'd3; ld_data = 32'hDEADBEEF;
      #1;
      chk("loader blocks req_ready", rdy[d], 1'b0);
      tick();
      rst_n = 1'b1;
      ld_addr = 7'd0; ld_data = 32'h20020005; tick();
      ld_addr = 7'd1; ld_data = 32'h2003000C; tick();
      ld_addr = 7'd2; ld_data = 32'h20670009; tick();
      ld_en = 1'b0;
      chk("reset request discarded", fcnt[d], 32'd0);

      // Back-to-back fetches of 0x0 and 0x4.
      reqv[d] = 1'b1; req_addr = 32'h0;
      tick();
      req_addr = 32'h4;
      if (d == 0) expect_rsp(d, 32'h20020005, 32'h0, 1'b0);
      else        chk("b2b first not yet", rv[d], 1'b0);
      tick();
      reqv[d] = 1'b0;
      if (d == 0) expect_rsp(d, 32'h2003000C, 32'h4, 1'b0);
      else        expect_rsp(d, 32'h20020005, 32'h0, 1'b0);
      tick();
      if (d == 1) expect_rsp(d, 32'h2003000C, 32'h4, 1'b0);
      else        chk("b2b drained", rv[d], 1'b0);
      tick();
      chk("b2b idle", rv[d], 1'b0);
      chk("b2b fetch_cnt", fcnt[d], 32'd2);

      fetch_one(d, 32'h8, 32'h20670009, 1'b0);
      chk("fetch_cnt after 0x8", fcnt[d], 32'd3);

      // Misaligned, out of range, and the last in-range word.
      fetch_one(d, 32'h6, 32'h0, 1'b1);
      fetch_one(d, 32'h200, 32'h0, 1'b1);
      fetch_one(d, 32'h1FC, 32'h0, 1'b0);
      chk("err_cnt after errors", ecnt[d], 16'd2);
      chk("fetch_cnt after errors", fcnt[d], 32'd6);

      // Back-pressure with requests still pending.
      fork
        begin
          present(d, 32'h4);
          present(d, 32'h8);
          present(d, 32'h0);
          reqv[d] = 1'b0;
        end
        stall(d);
      join
      repeat (4) tick();
      chk("drain no loss", mq[d].size(), 32'd0);
      chk("drain idle", rv[d], 1'b0);
      chk("drain fetch_cnt", fcnt[d], 32'd9);

      // Loader and request in the same cycle.
      ld_en = 1'b1; ld_addr = 7'd0; ld_data = 32'h00E22025;
      reqv[d] = 1'b1; req_addr = 32'h0;
      #1;
      chk("ld+req req_ready", rdy[d], 1'b0);
      tick();
      ld_en = 1'b0;
      chk("ld+req not accepted", fcnt[d], 32'd9);
      fetch_one(d, 32'h0, 32'h00E22025, 1'b0);
      chk("ld+req fetch_cnt", fcnt[d], 32'd10);

      // Reset with fetches in flight.
      reqv[d] = 1'b1; req_addr = 32'h4;
      tick();
      req_addr = 32'h8; rst_n = 1'b0;
      if (d == 1) chk("inflight hidden", rv[d], 1'b0);
      tick();
      rst_n = 1'b1; reqv[d] = 1'b0;
      chk("mid reset rsp_valid", rv[d], 1'b0);
      chk("mid reset fetch_cnt", fcnt[d], 32'd0);
      chk("mid reset err_cnt", ecnt[d], 16'd0);
      tick();
      chk("mid reset no response", rv[d], 1'b0);
      fetch_one(d, 32'h8, 32'h20670009, 1'b0);
      fetch_one(d, 32'hC, 32'hDEADBEEF, 1'b0);
      chk("post reset fetch_cnt", fcnt[d], 32'd2);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
